// File: rtl/note_seq_pkg.sv
// rtl/note_seq_pkg.sv - shared states, tempo encodings and slot-length helper for note_sequencer
package note_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] TEMPO_NORM = 2'd0;
  localparam logic [1:0] TEMPO_3Q   = 2'd1;
  localparam logic [1:0] TEMPO_HALF = 2'd2;
  localparam logic [1:0] TEMPO_SLOW = 2'd3;

  localparam logic [7:0] REST = 8'd0;

  // Shift-only scaling keeps the tempo multiplier out of the datapath.
  function automatic logic [31:0] slot_len(input logic [31:0] base, input logic [1:0] sel);
    case (sel)
      TEMPO_3Q:   return (base >> 1) + (base >> 2);
      TEMPO_HALF: return base >> 1;
      TEMPO_SLOW: return base + (base >> 1);
      default:    return base;
    endcase
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - control, song ROM and note output bundle of note_sequencer
interface note_sequencer_if #(parameter int ADDR_W = 8);
  logic              play;
  logic              restart;
  logic [1:0]        tempo_sel;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_note;
  logic [7:0]        note;
  logic              note_valid;
  logic              step;
  logic              done;

  modport master (
    input  play, restart, tempo_sel, rom_note,
    output rom_addr, note, note_valid, step, done
  );

  modport slave (
    output play, restart, tempo_sel, rom_note,
    input  rom_addr, note, note_valid, step, done
  );
endinterface

// File: rtl/note_sequencer_slot_timer.sv
// rtl/note_sequencer_slot_timer.sv - per-slot length latch and counter with pause hold
module slot_timer
  import note_seq_pkg::*;
#(
  parameter int TICK_DIV = 8388608
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic       run,
  input  logic [1:0] tempo_sel,
  output logic       slot_end
);

  logic [31:0] len;
  logic [31:0] count;

  assign slot_end = run && (count == len - 32'd1);

  // Counter parks at L-1 after slot_end; the next load restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 32'd0;
      len   <= 32'(TICK_DIV);
    end else if (clear) begin
      count <= 32'd0;
    end else if (load) begin
      count <= 32'd0;
      len   <= slot_len(32'(TICK_DIV), tempo_sel);
    end else if (run && !slot_end) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - song ROM sequencer FSM; NOTE_SEQ_LOOP_EN selects endless looping playback
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int TICK_DIV = 8388608,
  parameter int SONG_LEN = 196,
  parameter int ADDR_W   = 8
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  note_sequencer_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        note;
  logic              note_valid;
  logic              step;
  logic              done;
  logic              load;
  logic              run;
  logic              slot_end;

  assign load = (state == ST_WAIT) && !bus.restart;
  assign run  = (state == ST_PLAY) && bus.play && !bus.restart;

  slot_timer #(.TICK_DIV(TICK_DIV)) u_slot_timer (
    .clk       (CLK100MHZ),
    .rst       (rst),
    .clear     (bus.restart),
    .load      (load),
    .run       (run),
    .tempo_sel (bus.tempo_sel),
    .slot_end  (slot_end)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state      <= ST_IDLE;
      rom_addr   <= '0;
      note       <= REST;
      note_valid <= 1'b0;
      step       <= 1'b0;
      done       <= 1'b0;
    end else if (bus.restart) begin
      rom_addr   <= '0;
      note       <= REST;
      note_valid <= 1'b0;
      step       <= 1'b0;
      done       <= 1'b0;
      state      <= bus.play ? ST_FETCH : ST_IDLE;
    end else begin
      step       <= 1'b0;
      note_valid <= 1'b0;
      case (state)
        ST_IDLE:  if (bus.play) state <= ST_FETCH;
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          note       <= bus.rom_note;
          step       <= 1'b1;
          note_valid <= bus.play && (bus.rom_note != REST);
          state      <= ST_PLAY;
        end
        ST_PLAY: begin
          if (slot_end) begin
            if (rom_addr < LAST_ADDR) begin
              rom_addr <= rom_addr + 1'b1;
              state    <= ST_FETCH;
            end else begin
`ifdef NOTE_SEQ_LOOP_EN
              rom_addr <= '0;
              state    <= ST_FETCH;
`else
              note  <= REST;
              done  <= 1'b1;
              state <= ST_DONE;
`endif
            end
          end else begin
            note_valid <= bus.play && (note != REST);
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_addr   = rom_addr;
  assign bus.note       = note;
  assign bus.note_valid = note_valid;
  assign bus.step       = step;
  assign bus.done       = done;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed bench for note_sequencer with a 4-slot song
module tb_note_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   k;

  always #5 clk = ~clk;

  note_sequencer_if #(.ADDR_W(8)) bus ();

  note_sequencer #(.TICK_DIV(8), .SONG_LEN(4), .ADDR_W(8)) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .bus       (bus)
  );

  function automatic logic [7:0] rom_val(input logic [7:0] a);
    case (a)
      8'd0:    return 8'd25;
      8'd1:    return 8'd27;
      8'd3:    return 8'd30;
      default: return 8'd0;
    endcase
  endfunction

  always_ff @(posedge clk) bus.rom_note <= rom_val(bus.rom_addr);

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles from the current negedge until the next step pulse, capped at 200.
  task automatic next_step(output int cyc);
    cyc = 0;
    do begin
      tick(1);
      cyc++;
    end while (!bus.step && cyc < 200);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(bus.rom_addr), 0);
    chk({tag, "_note"}, 32'(bus.note), 0);
    chk({tag, "_nv"}, 32'(bus.note_valid), 0);
    chk({tag, "_step"}, 32'(bus.step), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.play = 1'b0;
    bus.restart = 1'b0;
    bus.tempo_sel = 2'd0;
    tick(3);
    chk_reset_vals("reset");
    rst = 1'b0;
    tick(2);
    chk("idle_addr", 32'(bus.rom_addr), 0);
    chk("idle_step", 32'(bus.step), 0);

    // First note three cycles after play rises
    bus.play = 1'b1;
    tick(2);
    chk("first_pre_step", 32'(bus.step), 0);
    chk("first_pre_note", 32'(bus.note), 0);
    tick(1);
    chk("first_note", 32'(bus.note), 25);
    chk("first_step", 32'(bus.step), 1);
    chk("first_nv", 32'(bus.note_valid), 1);

    next_step(k);
    chk("slot0_period", 32'(k), 10);
    chk("slot1_note", 32'(bus.note), 27);
    chk("slot1_addr", 32'(bus.rom_addr), 1);

    // Pause at counter 3 of slot 1
    tick(3);
    bus.play = 1'b0;
    tick(20);
    chk("pause_note", 32'(bus.note), 27);
    chk("pause_nv", 32'(bus.note_valid), 0);
    chk("pause_addr", 32'(bus.rom_addr), 1);
    bus.play = 1'b1;
    next_step(k);
    chk("resume_cycles", 32'(k), 7);
    chk("slot2_note", 32'(bus.note), 0);
    chk("slot2_nv", 32'(bus.note_valid), 0);
    chk("slot2_addr", 32'(bus.rom_addr), 2);

    next_step(k);
    chk("slot2_period", 32'(k), 10);
    chk("slot3_note", 32'(bus.note), 30);
    chk("slot3_nv", 32'(bus.note_valid), 1);

`ifdef NOTE_SEQ_LOOP_EN
    next_step(k);
    chk("wrap_period", 32'(k), 10);
    chk("wrap_note", 32'(bus.note), 25);
    chk("wrap_addr", 32'(bus.rom_addr), 0);
    chk("wrap_done", 32'(bus.done), 0);
`else
    tick(7);
    chk("last_hold_note", 32'(bus.note), 30);
    chk("last_hold_done", 32'(bus.done), 0);
    tick(1);
    chk("end_done", 32'(bus.done), 1);
    chk("end_note", 32'(bus.note), 0);
    tick(50);
    chk("done_hold", 32'(bus.done), 1);
    chk("done_note", 32'(bus.note), 0);
    chk("done_nv", 32'(bus.note_valid), 0);
    chk("done_step", 32'(bus.step), 0);
`endif

    // Restart with play high
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    chk("rs_done", 32'(bus.done), 0);
    chk("rs_note", 32'(bus.note), 0);
    chk("rs_addr", 32'(bus.rom_addr), 0);
    tick(2);
    chk("rs_note25", 32'(bus.note), 25);
    chk("rs_step", 32'(bus.step), 1);

    // Tempo change mid-slot applies from the next slot
    tick(2);
    bus.tempo_sel = 2'd2;
    next_step(k);
    chk("tempo_slot0", 32'(k), 8);
    chk("tempo_s1_note", 32'(bus.note), 27);
    bus.tempo_sel = 2'd3;
    next_step(k);
    chk("tempo_half", 32'(k), 6);
    next_step(k);
    chk("tempo_slow", 32'(k), 14);
    chk("tempo_s3_note", 32'(bus.note), 30);
    bus.tempo_sel = 2'd0;

    // Restart lands on the slot-end cycle of a 12-cycle slot
    tick(11);
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    chk("coll_addr", 32'(bus.rom_addr), 0);
    chk("coll_done", 32'(bus.done), 0);
    chk("coll_note", 32'(bus.note), 0);
    tick(2);
    chk("coll_note25", 32'(bus.note), 25);
    chk("coll_step", 32'(bus.step), 1);
    next_step(k);
    chk("coll_period", 32'(k), 10);
    chk("coll_s1_note", 32'(bus.note), 27);

    // rst wins over a simultaneous restart
    rst = 1'b1;
    bus.restart = 1'b1;
    tick(1);
    chk_reset_vals("rst_rs");
    rst = 1'b0;
    bus.restart = 1'b0;
    bus.play = 1'b0;
    tick(3);
    chk("post_rst_note", 32'(bus.note), 0);
    chk("post_rst_step", 32'(bus.step), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
